dmem_byte_responder: RTL

//  Memory-side responder for CPU load/store traffic. It accepts one byte, half or word request at a time over a

---
 rtl/dmem_byte_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dmem_byte_responder.sv
// Byte/half/word data-memory responder: four 8-bit lane banks, valid/ready request and response.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses become errors instead of silently aligning.
module dmem_byte_responder #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic              we_reg;
   logic [1:0]        size_reg;
   logic              unsigned_reg;
   logic [ADDR_W+1:0] addr_reg;
   logic [31:0]       wdata_reg;

   logic              accept;
   logic              access_en;
   logic              misaligned;
   logic              req_err;
   logic [3:0]        lane_en;
   logic [3:0]        bank_we;
   logic [31:0]       lane_wdata;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       rd_word;
   logic [31:0]       load_data;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid && req_ready) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      req_ready = (state_reg == IDLE) && !rst;
      rsp_valid = (state_reg == RESP);
      access_en = (state_reg == ACCESS) && !rst;
      accept    = req_valid && req_ready;
      rsp_err   = rsp_valid && req_err;
      rsp_rdata = (rsp_valid && !req_err && !we_reg) ? load_data : 32'd0;
   end

   // Request fields are held for the whole ACCESS/RESP period so outputs stay stable.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_reg       <= req_we;
         size_reg     <= req_size;
         unsigned_reg <= req_unsigned;
         addr_reg     <= req_addr;
         wdata_reg    <= req_wdata;
      end
   end

`ifdef MISALIGN_TRAP_EN
   assign misaligned = ((size_reg == 2'b01) && addr_reg[0]) ||
                       ((size_reg == 2'b10) && (addr_reg[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign req_err   = (size_reg == 2'b11) || misaligned;
   assign word_addr = addr_reg[ADDR_W+1:2];

   // Lane enables and replicated store data; unaligned halves/words fall back to their aligned lanes.
   always_comb begin
      lane_en    = 4'b0000;
      lane_wdata = wdata_reg;
      case (size_reg)
         2'b00: begin
            lane_en    = 4'b0001 << addr_reg[1:0];
            lane_wdata = {4{wdata_reg[7:0]}};
         end
         2'b01: begin
            lane_en    = addr_reg[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_reg[15:0]}};
         end
         2'b10: begin
            lane_en    = 4'b1111;
            lane_wdata = wdata_reg;
         end
         default: begin
            lane_en    = 4'b0000;
            lane_wdata = wdata_reg;
         end
      endcase
   end

   assign bank_we = (access_en && we_reg && !req_err) ? lane_en : 4'b0000;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk) begin
            if (bank_we[gi]) begin
               mem[word_addr] <= lane_wdata[8*gi +: 8];
            end
            if (access_en) begin
               rd_q <= mem[word_addr];
            end
         end

         assign rd_word[8*gi +: 8] = rd_q;
      end
   endgenerate

   // Lane select and sign/zero extension of the registered read word.
   always_comb begin
      byte_sel  = rd_word[7:0];
      half_sel  = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
      load_data = rd_word;
      case (addr_reg[1:0])
         2'b00:   byte_sel = rd_word[7:0];
         2'b01:   byte_sel = rd_word[15:8];
         2'b10:   byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      case (size_reg)
         2'b00:   load_data = {{24{!unsigned_reg && byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{!unsigned_reg && half_sel[15]}}, half_sel};
         default: load_data = rd_word;
      endcase
   end

endmodule
